// File: rtl/pam4_ber_pkg.sv
// Shared definitions for the PAM4 BER checker: FSM states, PRBS9 taps,
// slicer level encodings and the level-to-bits gray decode.
package pam4_ber_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } ber_state_t;

    // x^9 + x^5 + 1
    localparam int PRBS_TAP_A = 9;
    localparam int PRBS_TAP_B = 5;

    // Symbols loaded straight from the line before the predictor is trusted
    localparam int SEARCH_SYMS = 5;

    localparam logic [1:0] LVL_M3 = 2'b00;
    localparam logic [1:0] LVL_M1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b10;
    localparam logic [1:0] LVL_P3 = 2'b11;

    // Returns {b0, b1}; b0 is the earlier bit in time
    function automatic logic [1:0] gray_decode(input logic [1:0] level);
        logic [1:0] bits;
        case (level)
            LVL_M3:  bits = 2'b00;
            LVL_M1:  bits = 2'b01;
            LVL_P1:  bits = 2'b11;
            LVL_P3:  bits = 2'b10;
            default: bits = 2'b00;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/pam4_ber_checker_prbs9.sv
// Two-bit-per-symbol PRBS9 predictor: emits the next two expected bits from
// its history and shifts in either the received or the predicted pair.
module prbs9_pred2
    import pam4_ber_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       shift,
    input  logic       load,
    input  logic [1:0] rx_bits,
    output logic [1:0] pred_bits
);

    // s[0] is the newest bit
    logic [PRBS_TAP_A-1:0] s;

    // Second bit uses the taps one position younger, as if b0 were already shifted in
    assign pred_bits = {s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1],
                        s[PRBS_TAP_A-2] ^ s[PRBS_TAP_B-2]};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s <= '0;
        end else if (shift) begin
            s <= {s[PRBS_TAP_A-3:0], (load ? rx_bits : pred_bits)};
        end
    end

endmodule

// File: rtl/pam4_ber_checker.sv
// PRBS9 bit-error-rate checker on PAM4 slicer level indices, 2-cycle latency.
// Define PAM4_BER_LOL_EN to compile in windowed loss-of-lock detection.
module pam4_ber_checker
    import pam4_ber_pkg::*;
#(
    parameter int NB_CNT    = 32,
    parameter int LOCK_SYMS = 16,
    parameter int WIN       = 256,
    parameter int ERR_TH    = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic [1:0]        i_level,
    input  logic              i_clear,
    output logic              o_locked,
    output logic              o_sym_err,
    output logic [NB_CNT-1:0] o_bit_count,
    output logic [NB_CNT-1:0] o_err_count
);

    localparam int CNT_MAX = (LOCK_SYMS > SEARCH_SYMS) ? LOCK_SYMS : SEARCH_SYMS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    function automatic logic [NB_CNT-1:0] sat_add_cnt(input logic [NB_CNT-1:0] acc,
                                                      input logic [1:0]        inc);
        logic [NB_CNT:0] sum;
        sum = {1'b0, acc} + {{(NB_CNT - 1){1'b0}}, inc};
        return sum[NB_CNT] ? {NB_CNT{1'b1}} : sum[NB_CNT-1:0];
    endfunction

    logic [1:0]        level_p0;
    logic              vld_p0;
    logic              accept_p1;
    logic              load_p1;
    logic [1:0]        rx_bits_p1;
    logic [1:0]        pred_bits_p1;
    logic [1:0]        mism_p1;
    logic [1:0]        pop_p1;
    logic              count_p1;
    logic              lol_trip_p1;
    ber_state_t        state;
    logic [CNT_W-1:0]  sym_cnt;
    logic              sym_err;
    logic [NB_CNT-1:0] bit_count;
    logic [NB_CNT-1:0] err_count;

    // Window settings are only consumed by loss-of-lock; a malformed window shows up here
    if (WIN < 2 || (WIN & (WIN - 1)) != 0 || ERR_TH < 0) begin : g_bad_window_cfg
    end

    // ---- Stage 0: input register ----
    always_ff @(posedge i_clock) begin
        if (i_enable && i_valid) begin
            level_p0 <= i_level;
        end
    end

    // ---- Stage 1: decode, predict, compare ----
    assign accept_p1  = i_enable && vld_p0;
    assign load_p1    = (state == ST_SEARCH);
    assign rx_bits_p1 = gray_decode(level_p0);
    assign mism_p1    = rx_bits_p1 ^ pred_bits_p1;
    assign pop_p1     = {1'b0, mism_p1[1]} + {1'b0, mism_p1[0]};
    // A clear in the same cycle swallows the symbol for all statistics
    assign count_p1   = accept_p1 && (state == ST_LOCKED) && !i_clear;

    prbs9_pred2 u_pred (
        .clock     (i_clock),
        .rst_n     (i_reset),
        .shift     (accept_p1),
        .load      (load_p1),
        .rx_bits   (rx_bits_p1),
        .pred_bits (pred_bits_p1)
    );

`ifdef PAM4_BER_LOL_EN
    localparam int WACC_W = $clog2(2 * WIN + 1);
    localparam int WCNT_W = $clog2(WIN);

    logic [WCNT_W-1:0] win_cnt;
    logic [WACC_W-1:0] win_acc;
    logic [WACC_W-1:0] win_acc_next;

    function automatic logic [WACC_W-1:0] sat_add_win(input logic [WACC_W-1:0] acc,
                                                      input logic [1:0]        inc);
        logic [WACC_W:0] sum;
        sum = {1'b0, acc} + {{(WACC_W - 1){1'b0}}, inc};
        return sum[WACC_W] ? {WACC_W{1'b1}} : sum[WACC_W-1:0];
    endfunction

    assign win_acc_next = sat_add_win(win_acc, pop_p1);
    assign lol_trip_p1  = count_p1 && (int'(win_acc_next) > ERR_TH);

    // Trip is checked before the wrap, so the last symbol of a window can still drop lock
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            win_cnt <= '0;
            win_acc <= '0;
        end else if (i_clear || lol_trip_p1) begin
            win_cnt <= '0;
            win_acc <= '0;
        end else if (count_p1) begin
            if (win_cnt == WCNT_W'(WIN - 1)) begin
                win_cnt <= '0;
                win_acc <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                win_acc <= win_acc_next;
            end
        end
    end
`else
    assign lol_trip_p1 = 1'b0;
`endif

    // ---- Stage 1 -> outputs: FSM, statistics, error pulse ----
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            vld_p0    <= 1'b0;
            state     <= ST_SEARCH;
            sym_cnt   <= '0;
            sym_err   <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            sym_err <= count_p1 && (mism_p1 != 2'b00);

            if (i_enable) begin
                vld_p0 <= i_valid;
            end

            if (accept_p1) begin
                case (state)
                    ST_SEARCH: begin
                        if (sym_cnt == CNT_W'(SEARCH_SYMS - 1)) begin
                            state   <= ST_VERIFY;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        if (mism_p1 != 2'b00) begin
                            state   <= ST_SEARCH;
                            sym_cnt <= '0;
                        end else if (sym_cnt == CNT_W'(LOCK_SYMS - 1)) begin
                            state   <= ST_LOCKED;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (lol_trip_p1) begin
                            state   <= ST_SEARCH;
                            sym_cnt <= '0;
                        end
                    end
                    default: begin
                        state   <= ST_SEARCH;
                        sym_cnt <= '0;
                    end
                endcase
            end

            if (i_clear) begin
                bit_count <= '0;
                err_count <= '0;
            end else if (count_p1) begin
                bit_count <= sat_add_cnt(bit_count, 2'd2);
                err_count <= sat_add_cnt(err_count, pop_p1);
            end
        end
    end

    assign o_locked    = (state == ST_LOCKED);
    assign o_sym_err   = sym_err;
    assign o_bit_count = bit_count;
    assign o_err_count = err_count;

endmodule

// File: tb/tb_pam4_ber_checker.sv
// Directed bench for pam4_ber_checker with a queue-based reference model
// compared on every falling clock edge, plus literal spot checks.
module tb_pam4_ber_checker;

    localparam int     LOCK_N = 16;
    localparam int     WIN_N  = 256;
    localparam int     TH_N   = 32;
    localparam int     NLV    = 512;
    localparam longint CMAX   = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        vld = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  lvl = 2'b00;
    logic        locked;
    logic        sym_err;
    logic [31:0] bit_cnt;
    logic [31:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] lv [NLV];
    int         ptr = 0;

    // Reference model state (spec-level: 0 search, 1 verify, 2 locked)
    int         m_state = 0;
    int         m_cnt = 0;
    bit         hist[$];
    bit         m_vld = 1'b0;
    logic [1:0] m_lvl = 2'b00;
    longint     m_bits = 0;
    longint     m_errs = 0;
    bit         m_symerr = 1'b0;
    int         w_cnt = 0;
    int         w_acc = 0;

    pam4_ber_checker dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_enable    (en),
        .i_valid     (vld),
        .i_level     (lvl),
        .i_clear     (clr),
        .o_locked    (locked),
        .o_sym_err   (sym_err),
        .o_bit_count (bit_cnt),
        .o_err_count (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_vld = 1'b0; m_lvl = 2'b00;
        m_bits = 0; m_errs = 0; m_symerr = 1'b0; w_cnt = 0; w_acc = 0;
        hist = {};
        repeat (9) hist.push_back(1'b0);
    endtask

    task automatic model_symbol(input logic [1:0] l, input bit counting);
        bit rb0, rb1, pb0, pb1;
        int n, pop;
        rb0 = l[1];
        rb1 = l[1] ^ l[0];
        n   = hist.size();
        pb0 = hist[n-9] ^ hist[n-5];
        pb1 = hist[n-8] ^ hist[n-4];
        pop = int'(rb0 ^ pb0) + int'(rb1 ^ pb1);
        if (m_state == 0) begin
            hist.push_back(rb0); hist.push_back(rb1);
        end else begin
            hist.push_back(pb0); hist.push_back(pb1);
        end
        while (hist.size() > 9) void'(hist.pop_front());
        if (m_state == 0) begin
            m_cnt++;
            if (m_cnt == 5) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
            if (pop != 0) begin
                m_state = 0; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == LOCK_N) begin m_state = 2; m_cnt = 0; end
            end
        end else if (counting) begin
            m_bits   = sat(m_bits + 2);
            m_errs   = sat(m_errs + pop);
            m_symerr = (pop != 0);
`ifdef PAM4_BER_LOL_EN
            w_acc += pop;
            w_cnt++;
            if (w_acc > TH_N) begin
                m_state = 0; m_cnt = 0; w_acc = 0; w_cnt = 0;
            end else if (w_cnt == WIN_N) begin
                w_acc = 0; w_cnt = 0;
            end
`endif
        end
    endtask

    task automatic model_step();
        m_symerr = 1'b0;
        if (en) begin
            if (m_vld) model_symbol(m_lvl, !clr);
            m_vld = vld;
            if (vld) m_lvl = lvl;
        end
        if (clr) begin
            m_bits = 0; m_errs = 0; w_cnt = 0; w_acc = 0;
        end
    endtask

    task automatic send(input logic [1:0] l);
        @(negedge clk);
        en = 1'b1; vld = 1'b1; lvl = l;
    endtask

    task automatic send_clean();
        send(lv[ptr]);
        if (ptr < NLV - 1) ptr++;
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic flush();
        idle();
        idle();
    endtask

    initial begin
        bit g[$];
        bit b0, b1;
        int n;
        // PRBS9 transmit stream, history seeded all-ones
        repeat (9) g.push_back(1'b1);
        for (int i = 0; i < NLV; i++) begin
            n  = g.size(); b0 = g[n-9] ^ g[n-5]; g.push_back(b0);
            n  = g.size(); b1 = g[n-9] ^ g[n-5]; g.push_back(b1);
            lv[i] = {b0, b0 ^ b1};
        end
        model_reset();

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else        model_step();
            end
            forever begin
                @(negedge clk);
                check("cyc_locked",  longint'(locked),  longint'(m_state == 2));
                check("cyc_sym_err", longint'(sym_err), longint'(m_symerr));
                check("cyc_bits",    longint'(bit_cnt), m_bits);
                check("cyc_errs",    longint'(err_cnt), m_errs);
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_locked", longint'(locked), 0);
        check("rst_sym_err", longint'(sym_err), 0);
        check("rst_bits", longint'(bit_cnt), 0);
        check("rst_errs", longint'(err_cnt), 0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Acquisition: lock follows the 21st symbol
        repeat (20) send_clean();
        flush();
        check("lock_before_21", longint'(locked), 0);
        send_clean();
        flush();
        check("lock_after_21", longint'(locked), 1);
        check("bits_at_lock", longint'(bit_cnt), 0);
        repeat (100) send_clean();
        flush();
        check("bits_after_100", longint'(bit_cnt), 200);
        check("errs_after_100", longint'(err_cnt), 0);

        // Expected -1 (01), sent -3 (00): one bit wrong
        while (lv[ptr] != 2'b01 && ptr < NLV - 64) send_clean();
        send(2'b00); ptr++;
        idle(); idle();
        check("sym_err_pulse", longint'(sym_err), 1);
        check("err_1bit", longint'(err_cnt), 1);
        idle();
        check("sym_err_end", longint'(sym_err), 0);

        // Enable low: garbage on the line is ignored
        @(negedge clk); en = 1'b0; vld = 1'b1; lvl = ~lv[ptr];
        repeat (2) @(negedge clk);
        en = 1'b1; vld = 1'b0;
        idle();
        check("enable_hold_errs", longint'(err_cnt), 1);

        // Expected +1 (10 -> bits 11), sent -3 (bits 00): two bits wrong
        while (lv[ptr] != 2'b10 && ptr < NLV - 64) send_clean();
        send(2'b00); ptr++;
        flush();
        check("err_2bit", longint'(err_cnt), 3);

        // Clear held across an errored symbol: nothing survives
        @(negedge clk); vld = 1'b1; lvl = ~lv[ptr]; clr = 1'b1; ptr++;
        @(negedge clk); vld = 1'b0;
        @(negedge clk); clr = 1'b0;
        check("clear_bits", longint'(bit_cnt), 0);
        check("clear_errs", longint'(err_cnt), 0);
        idle();
        check("clear_errs_hold", longint'(err_cnt), 0);
        repeat (10) send_clean();
        flush();
        check("bits_after_clear", longint'(bit_cnt), 20);

        // Random levels: lock drops only with loss-of-lock compiled in
        repeat (300) send(2'($urandom_range(0, 3)));
        flush();
`ifdef PAM4_BER_LOL_EN
        check("random_lock_lost", longint'(locked), 0);
`else
        check("random_lock_sticky", longint'(locked), 1);
`endif

        // Asynchronous reset mid-run
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_locked", longint'(locked), 0);
        check("async_sym_err", longint'(sym_err), 0);
        check("async_bits", longint'(bit_cnt), 0);
        check("async_errs", longint'(err_cnt), 0);
        @(negedge clk); rst_n = 1'b1;

        // Corrupt the 10th symbol (in VERIFY): lock moves to the 31st
        repeat (9) send_clean();
        send(lv[ptr] ^ 2'b01); ptr++;
        repeat (20) send_clean();
        flush();
        check("relock_early", longint'(locked), 0);
        send_clean();
        flush();
        check("relock", longint'(locked), 1);
        check("relock_bits", longint'(bit_cnt), 0);
        check("relock_errs", longint'(err_cnt), 0);

        flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
